// File: rtl/onehot_decoder_seq.sv
// Sequential binary-to-one-hot decoder: holds each code HOLD cycles, then one all-zero gap cycle.
// Optional DEC_PIPE_EN adds a one-entry pending register so the next code follows the gap directly.
module onehot_decoder_seq #(
    parameter int unsigned IN_W  = 2,
    parameter int unsigned OUT_W = 4,
    parameter int unsigned HOLD  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic             done,
    output logic             busy
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic               load;
    logic [IN_W-1:0]    load_idx;
    logic               hs;
    logic [OUT_W-1:0]   out_n;
    logic               out_valid_n;
    logic               done_n;
    logic               busy_n;
    logic               in_ready_n;

    assign hs = in_valid && in_ready;

`ifdef DEC_PIPE_EN
    logic               pend_v;
    logic               pend_v_n;
    logic [IN_W-1:0]    pend;
    logic [IN_W-1:0]    pend_n;

    // Pending entry fills from a handshake during DRIVE and drains when GAP hands over to DRIVE.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v <= 1'b0;
            pend   <= '0;
        end else begin
            pend_v <= pend_v_n;
            pend   <= pend_n;
        end
    end
`endif

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            out       <= out_n;
            out_valid <= out_valid_n;
            done      <= done_n;
            busy      <= busy_n;
            in_ready  <= in_ready_n;
        end
    end

    // Next state, hold counter and which index (if any) starts a new code.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        load     = 1'b0;
        load_idx = in;
`ifdef DEC_PIPE_EN
        pend_v_n = pend_v;
        pend_n   = pend;
`endif
        case (state)
            IDLE: begin
                if (hs) begin
                    load = 1'b1;
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    state_n = GAP;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
`ifdef DEC_PIPE_EN
                if (hs) begin
                    pend_v_n = 1'b1;
                    pend_n   = in;
                end
`endif
            end
            GAP: begin
                state_n = IDLE;
`ifdef DEC_PIPE_EN
                // A handshake landing in GAP with the entry empty goes straight to DRIVE.
                if (pend_v) begin
                    load     = 1'b1;
                    load_idx = pend;
                    pend_v_n = 1'b0;
                end else if (hs) begin
                    load = 1'b1;
                end
`endif
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (load) begin
            state_n = DRIVE;
            cnt_n   = CNT_W'(HOLD - 1);
        end
    end

    // Output values for the next cycle, derived from the next state.
    always_comb begin
        out_n       = '0;
        out_valid_n = (state_n == DRIVE);
        done_n      = (state_n == GAP);
        busy_n      = (state_n != IDLE);
`ifdef DEC_PIPE_EN
        in_ready_n  = (state_n == IDLE) || !pend_v_n;
`else
        in_ready_n  = (state_n == IDLE);
`endif
        if (load) begin
            out_n = OUT_W'(1) << load_idx;
        end else if (state_n == DRIVE) begin
            out_n = out;
        end
    end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed self-checking bench for onehot_decoder_seq (HOLD=3); DEC_PIPE_EN selects the pipelined checks.
module tb_onehot_decoder_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in;
    logic [3:0] out;
    logic       out_valid;
    logic       done;
    logic       busy;

    int errors;
    int checks;
    int cyc;

`ifdef DEC_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    onehot_decoder_seq #(.IN_W(2), .OUT_W(4), .HOLD(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .out       (out),
        .out_valid (out_valid),
        .done      (done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in       = 2'b11;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({out, out_valid, done, busy, in_ready} !== {4'b0000, 1'b0, 1'b0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL reset_%0d: out=%b v=%b done=%b busy=%b rdy=%b, required 0000 0 0 0 1",
                         i, out, out_valid, done, busy, in_ready);
            end
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out, out_valid, busy} !== {4'b0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_nothing_accepted: out=%b v=%b busy=%b, required 0000 0 0", out, out_valid, busy);
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1;
        in       = 2'b10;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({out, out_valid, done, busy, in_ready} !== {4'b0100, 1'b1, 1'b0, 1'b1, PIPE}) begin
                errors++;
                $display("FAIL single_drive_%0d: out=%b v=%b done=%b busy=%b rdy=%b, required 0100 1 0 1 %b",
                         i, out, out_valid, done, busy, in_ready, PIPE);
            end
            @(negedge clk);
        end
        checks++;
        if ({out, out_valid, done, busy} !== {4'b0000, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL single_gap: out=%b v=%b done=%b busy=%b, required 0000 0 1 1", out, out_valid, done, busy);
        end
        @(negedge clk);
        checks++;
        if ({out, done, busy, in_ready} !== {4'b0000, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL single_idle: out=%b done=%b busy=%b rdy=%b, required 0000 0 0 1", out, done, busy, in_ready);
        end
    endtask

    task automatic test_sweep();
        logic [3:0] exp_code [4];
        int last_acc;
        int n;
        exp_code[0] = 4'b0001;
        exp_code[1] = 4'b0010;
        exp_code[2] = 4'b0100;
        exp_code[3] = 4'b1000;
        last_acc = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!in_ready && n < 20) begin
                checks++;
                if ($countones(out) > 1) begin
                    errors++;
                    $display("FAIL sweep_popcount: out=%b, required at most one bit set", out);
                end
                @(negedge clk);
                n++;
            end
            checks++;
            if (!in_ready) begin
                errors++;
                $display("FAIL sweep_ready_timeout_%0d: in_ready=%b after %0d cycles, required 1", k, in_ready, n);
            end
            if (k > 0) begin
                checks++;
                if (cyc - last_acc !== 5) begin
                    errors++;
                    $display("FAIL sweep_spacing_%0d: %0d edges, required 5", k, cyc - last_acc);
                end
            end
            last_acc = cyc;
            in_valid = 1'b1;
            in       = 2'(k);
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if ({out, out_valid} !== {exp_code[k], 1'b1}) begin
                errors++;
                $display("FAIL sweep_code_%0d: out=%b v=%b, required %b 1", k, out, out_valid, exp_code[k]);
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1;
        in       = 2'b11;
        @(negedge clk);
        in = 2'b01;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({out, in_ready} !== {4'b1000, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold_%0d: out=%b rdy=%b, required 1000 0", i, out, in_ready);
            end
            @(negedge clk);
        end
        checks++;
        if ({out, done, in_ready} !== {4'b0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL bp_gap: out=%b done=%b rdy=%b, required 0000 1 0", out, done, in_ready);
        end
        @(negedge clk);
        checks++;
        if ({out, in_ready} !== {4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL bp_idle: out=%b rdy=%b, required 0000 1", out, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out, out_valid} !== {4'b0010, 1'b1}) begin
            errors++;
            $display("FAIL bp_second_code: out=%b v=%b, required 0010 1", out, out_valid);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_drive();
        in_valid = 1'b1;
        in       = 2'b10;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out !== 4'b0100) begin
            errors++;
            $display("FAIL rmd_drive: out=%b, required 0100", out);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({out, out_valid, done, busy, in_ready} !== {4'b0000, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rmd_after_rst: out=%b v=%b done=%b busy=%b rdy=%b, required 0000 0 0 0 1",
                     out, out_valid, done, busy, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({out, done} !== {4'b0000, 1'b0}) begin
                errors++;
                $display("FAIL rmd_no_done_%0d: out=%b done=%b, required 0000 0", i, out, done);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_out [8];
        logic       exp_done [8];
        exp_out[0] = 4'b0001; exp_out[1] = 4'b0001; exp_out[2] = 4'b0001; exp_out[3] = 4'b0000;
        exp_out[4] = 4'b1000; exp_out[5] = 4'b1000; exp_out[6] = 4'b1000; exp_out[7] = 4'b0000;
        for (int i = 0; i < 8; i++) exp_done[i] = (i == 3) || (i == 7);
        in_valid = 1'b1;
        in       = 2'b00;
        @(negedge clk);
        in = 2'b11;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({out, done} !== {exp_out[i], exp_done[i]}) begin
                errors++;
                $display("FAIL b2b_cycle_%0d: out=%b done=%b, required %b %b", i, out, done, exp_out[i], exp_done[i]);
            end
            if (i == 1) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_pend_full: in_ready=%b, required 0", in_ready);
                end
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        cyc      = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in       = '0;
        test_reset();
        test_single();
`ifdef DEC_PIPE_EN
        test_back_to_back();
`else
        test_sweep();
        test_backpressure();
`endif
        test_reset_mid_drive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
